// File: rtl/wb_pipe_stage_if.sv
// wb_pipe_stage_if: valid/ready bus carrying one write-back entry.
//   master drives valid + payload (wdata, rd_en, rd_addr, pc, inst)
//   slave  drives ready
// The same interface type is used on the LSU side (stage is slave) and on
// the WB side (stage is master).
interface wb_pipe_stage_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int PCW = 32
);
    logic           valid;
    logic           ready;
    logic [DW-1:0]  wdata;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [PCW-1:0] pc;
    logic [PCW-1:0] inst;

    modport master (output valid, wdata, rd_en, rd_addr, pc, inst, input ready);
    modport slave  (input valid, wdata, rd_en, rd_addr, pc, inst, output ready);
endinterface

// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: LSU -> WB pipeline stage with valid/ready handshake,
// optional two-entry skid buffer, synchronous flush, x0 write suppression
// and a retired-instruction counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous kill of all held entries (out_fire still counts)
//   in_bus      : LSU side (slave modport), in_bus.ready registered if SKID=1
//   out_bus     : WB side (master modport), driven from the head entry
//   retire_cnt  : number of output handshakes, wraps modulo 2^CNT_W
module wb_pipe_stage #(
    parameter int             DW         = 32,
    parameter int             AW         = 5,
    parameter int             PCW        = 32,
    parameter int             SKID       = 1,
    parameter int             CNT_W      = 64,
    parameter logic [PCW-1:0] RESET_INST = PCW'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    wb_pipe_stage_if.slave   in_bus,
    wb_pipe_stage_if.master  out_bus,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef struct packed {
        logic [DW-1:0]  wdata;
        logic           rd_en;
        logic [AW-1:0]  rd_addr;
        logic [PCW-1:0] pc;
        logic [PCW-1:0] inst;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, FULL, SKID_FULL} state_t;

    localparam entry_t ENTRY_RST = '{wdata: '0, rd_en: 1'b0, rd_addr: '0,
                                     pc: '0, inst: RESET_INST};

    state_t           state_q;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           in_ent;
    logic             rdy_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;

    assign in_ent = '{wdata: in_bus.wdata, rd_en: in_bus.rd_en, rd_addr: in_bus.rd_addr,
                      pc: in_bus.pc, inst: in_bus.inst};

    assign out_valid = (state_q != EMPTY);
    // SKID=1: ready comes straight from a flop so WB back-pressure never
    // reaches the LSU combinationally. SKID=0: classic pass-through ready.
    assign in_bus.ready = (SKID != 0) ? rdy_q : (!out_valid || out_bus.ready);

    assign in_fire  = in_bus.valid && in_bus.ready;
    assign out_fire = out_valid && out_bus.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= ENTRY_RST;
            skid_q  <= ENTRY_RST;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            // A consumed head is retired even in a flush cycle.
            if (out_fire) cnt_q <= cnt_q + CNT_W'(1);

            if (flush) begin
                state_q     <= EMPTY;
                rdy_q       <= 1'b1;
                main_q.inst <= RESET_INST;
                skid_q.inst <= RESET_INST;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            main_q  <= in_ent;
                            state_q <= FULL;
                        end
                    end
                    FULL: begin
                        if (in_fire && out_fire) begin
                            main_q <= in_ent;
                        end else if (in_fire) begin
                            // Only reachable with SKID=1 (SKID=0 ready blocks it).
                            if (SKID != 0) begin
                                skid_q  <= in_ent;
                                state_q <= SKID_FULL;
                                rdy_q   <= 1'b0;
                            end
                        end else if (out_fire) begin
                            state_q <= EMPTY;
                        end
                    end
                    SKID_FULL: begin
                        if (out_fire) begin
                            main_q  <= skid_q;
                            state_q <= FULL;
                            rdy_q   <= 1'b1;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    assign out_bus.valid   = out_valid;
    assign out_bus.wdata   = main_q.wdata;
    // Writes to x0 are architecturally discarded; gate the enable here.
    assign out_bus.rd_en   = main_q.rd_en && out_valid && (main_q.rd_addr != '0);
    assign out_bus.rd_addr = main_q.rd_addr;
    assign out_bus.pc      = main_q.pc;
    assign out_bus.inst    = main_q.inst;
    assign retire_cnt      = cnt_q;

endmodule
